// File: rtl/efuse_controller.sv
// Bit-serial eFuse sequencer: 32-bit read and program with setup/strobe/hold timing.
// Define EFUSE_PGM_VERIFY_EN to add a read-back verify pass after every program.
module efuse_controller #(
    parameter int T_SETUP = 2,
    parameter int T_RD    = 4,
    parameter int T_PGM   = 400,
    parameter int T_HOLD  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] data_write,
    input  logic        ack,
    output logic        rd_done,
    output logic        wr_done,
    output logic [31:0] data_read,
    output logic [4:0]  efuse_addr,
    output logic        efuse_rden,
    output logic        efuse_pgmen,
    output logic        efuse_strobe,
    input  logic        efuse_q,
    output logic        pgm_err
);
    localparam int T_SETUP_E = (T_SETUP > 0) ? T_SETUP : 1;
    localparam int T_RD_E    = (T_RD    > 0) ? T_RD    : 1;
    localparam int T_PGM_E   = (T_PGM   > 0) ? T_PGM   : 1;
    localparam int T_HOLD_E  = (T_HOLD  > 0) ? T_HOLD  : 1;
    localparam int T_MAX_A   = (T_PGM_E > T_RD_E) ? T_PGM_E : T_RD_E;
    localparam int T_MAX_B   = (T_SETUP_E > T_HOLD_E) ? T_SETUP_E : T_HOLD_E;
    localparam int T_MAX     = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int CNT_W     = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_NEXT, S_DONE, S_VERIFY
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   tmr_q, tmr_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic               pgm_mode_q, pgm_mode_d;
    logic [31:0]        mask_q, mask_d;
    logic [31:0]        shadow_q, shadow_d;
    logic [31:0]        data_read_q, data_read_d;
    logic               rd_done_q, rd_done_d;
    logic               wr_done_q, wr_done_d;
    logic               read_prev_q, write_prev_q;
    logic               read_rise, write_rise;
    logic               active;
    logic [CNT_W-1:0]   strobe_last;
`ifdef EFUSE_PGM_VERIFY_EN
    logic               verify_q, verify_d;
    logic               pgm_err_q, pgm_err_d;
`endif

    assign read_rise   = read & ~read_prev_q;
    assign write_rise  = write & ~write_prev_q;
    assign strobe_last = pgm_mode_q ? CNT_W'(T_PGM_E - 1) : CNT_W'(T_RD_E - 1);

    always_comb begin
        // NOTE: every next-state signal takes a default first so no branch can infer a latch.
        state_d     = state_q;
        tmr_d       = tmr_q + 1'b1;
        bit_cnt_d   = bit_cnt_q;
        pgm_mode_d  = pgm_mode_q;
        mask_d      = mask_q;
        shadow_d    = shadow_q;
        data_read_d = data_read_q;
        rd_done_d   = 1'b0;
        wr_done_d   = 1'b0;
`ifdef EFUSE_PGM_VERIFY_EN
        verify_d    = verify_q;
        pgm_err_d   = pgm_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                tmr_d     = '0;
                bit_cnt_d = '0;
                // Write has priority when both requests rise together.
                if (write_rise) begin
                    mask_d     = data_write;
                    pgm_mode_d = 1'b1;
                    state_d    = S_SETUP;
`ifdef EFUSE_PGM_VERIFY_EN
                    verify_d   = 1'b0;
                    pgm_err_d  = 1'b0;
`endif
                end else if (read_rise) begin
                    pgm_mode_d = 1'b0;
                    state_d    = S_SETUP;
`ifdef EFUSE_PGM_VERIFY_EN
                    verify_d   = 1'b0;
`endif
                end
            end
            S_SETUP: begin
                if (tmr_q == CNT_W'(T_SETUP_E - 1)) begin
                    tmr_d   = '0;
                    state_d = (pgm_mode_q && !mask_q[bit_cnt_q]) ? S_NEXT : S_STROBE;
                end
            end
            S_STROBE: begin
                if (tmr_q == strobe_last) begin
                    tmr_d   = '0;
                    state_d = S_HOLD;
                    if (!pgm_mode_q) begin
                        shadow_d[bit_cnt_q] = efuse_q;
                    end
                end
            end
            S_HOLD: begin
                if (tmr_q == CNT_W'(T_HOLD_E - 1)) begin
                    tmr_d   = '0;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                tmr_d = '0;
                if (bit_cnt_q != 5'd31) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    state_d   = S_SETUP;
                end else if (pgm_mode_q) begin
`ifdef EFUSE_PGM_VERIFY_EN
                    state_d   = S_VERIFY;
`else
                    wr_done_d = 1'b1;
                    state_d   = S_DONE;
`endif
                end else begin
                    data_read_d = shadow_q;
                    state_d     = S_DONE;
`ifdef EFUSE_PGM_VERIFY_EN
                    if (verify_q) begin
                        pgm_err_d = (shadow_q & mask_q) != mask_q;
                        wr_done_d = 1'b1;
                    end else begin
                        rd_done_d = 1'b1;
                    end
`else
                    rd_done_d   = 1'b1;
`endif
                end
            end
`ifdef EFUSE_PGM_VERIFY_EN
            S_VERIFY: begin
                // Re-run the bit loop in read mode; the end of that read reports the program.
                tmr_d      = '0;
                bit_cnt_d  = '0;
                pgm_mode_d = 1'b0;
                verify_d   = 1'b1;
                state_d    = S_SETUP;
            end
`endif
            S_DONE: begin
                tmr_d = '0;
                if (ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                tmr_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tmr_q        <= '0;
            bit_cnt_q    <= '0;
            pgm_mode_q   <= 1'b0;
            mask_q       <= '0;
            shadow_q     <= '0;
            data_read_q  <= '0;
            rd_done_q    <= 1'b0;
            wr_done_q    <= 1'b0;
            read_prev_q  <= 1'b0;
            write_prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            bit_cnt_q    <= bit_cnt_d;
            pgm_mode_q   <= pgm_mode_d;
            mask_q       <= mask_d;
            shadow_q     <= shadow_d;
            data_read_q  <= data_read_d;
            rd_done_q    <= rd_done_d;
            wr_done_q    <= wr_done_d;
            read_prev_q  <= read;
            write_prev_q <= write;
        end
    end

`ifdef EFUSE_PGM_VERIFY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            verify_q  <= 1'b0;
            pgm_err_q <= 1'b0;
        end else begin
            verify_q  <= verify_d;
            pgm_err_q <= pgm_err_d;
        end
    end

    assign pgm_err = pgm_err_q;
`else
    assign pgm_err = 1'b0;
`endif

    // Macro controls are decoded from state so reset drops them in the same cycle.
    assign active       = (state_q == S_SETUP) || (state_q == S_STROBE) ||
                          (state_q == S_HOLD)  || (state_q == S_NEXT);
    assign efuse_strobe = (state_q == S_STROBE);
    assign efuse_rden   = active & ~pgm_mode_q;
    assign efuse_pgmen  = active & pgm_mode_q;
    assign efuse_addr   = active ? bit_cnt_q : 5'd0;
    assign data_read    = data_read_q;
    assign rd_done      = rd_done_q;
    assign wr_done      = wr_done_q;

endmodule
